// File: rtl/ex_stage_param_if.sv
// Port bundle for ex_stage_param: ID/EX operands and control, MEM/WB forwarding
// source, pipeline stall/flush, and the registered EX/MEM outputs.
interface ex_stage_param_if #(
    parameter int W   = 32,
    parameter int RAW = 5
);
    logic           in_valid;
    logic [W-1:0]   rs_data;
    logic [W-1:0]   rt_data;
    logic [W-1:0]   imm;
    logic [RAW-1:0] rs;
    logic [RAW-1:0] rt;
    logic [RAW-1:0] rd;
    logic           alu_src;
    logic           reg_dst;
    logic [3:0]     alu_op;
    logic           reg_write_in;
    logic           mem_to_reg_in;
    logic           mem_read_in;
    logic           mem_write_in;
    logic           branch_in;
    logic           wb_reg_write;
    logic [RAW-1:0] wb_dest;
    logic [W-1:0]   wb_data;
    logic           mem_stall;
    logic           flush;
    logic           stall_out;
    logic           ex_valid;
    logic [W-1:0]   ex_result;
    logic           ex_zero;
    logic [W-1:0]   ex_store_data;
    logic [RAW-1:0] ex_dest;
    logic           ex_reg_write;
    logic           ex_mem_to_reg;
    logic           ex_mem_read;
    logic           ex_mem_write;
    logic           ex_branch;

    // master drives the stage (ID/EX side), slave is the execute stage itself
    modport master (
        output in_valid, rs_data, rt_data, imm, rs, rt, rd, alu_src, reg_dst, alu_op,
        output reg_write_in, mem_to_reg_in, mem_read_in, mem_write_in, branch_in,
        output wb_reg_write, wb_dest, wb_data, mem_stall, flush,
        input  stall_out, ex_valid, ex_result, ex_zero, ex_store_data, ex_dest,
        input  ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch
    );

    modport slave (
        input  in_valid, rs_data, rt_data, imm, rs, rt, rd, alu_src, reg_dst, alu_op,
        input  reg_write_in, mem_to_reg_in, mem_read_in, mem_write_in, branch_in,
        input  wb_reg_write, wb_dest, wb_data, mem_stall, flush,
        output stall_out, ex_valid, ex_result, ex_zero, ex_store_data, ex_dest,
        output ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch
    );
endinterface

// File: rtl/ex_stage_param.sv
// Parametrised execute stage with forwarding, ALU and EX/MEM register.
// Define EX_MUL_EN to build the iterative shift-add multiplier (alu_op 10).
module ex_stage_param #(
    parameter int W   = 32,
    parameter int RAW = 5
) (
    input  logic            clk,
    input  logic            rst,
    ex_stage_param_if.slave bus
);
    localparam int SW = $clog2(W);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOR = 4'd5;
    localparam logic [3:0] OP_SLT = 4'd6;
    localparam logic [3:0] OP_SLL = 4'd7;
    localparam logic [3:0] OP_SRL = 4'd8;
    localparam logic [3:0] OP_SRA = 4'd9;

    // EX/MEM register; control bit order {branch, mem_write, mem_read, mem_to_reg, reg_write}
    logic           ex_valid_reg;
    logic [W-1:0]   ex_result_reg;
    logic           ex_zero_reg;
    logic [W-1:0]   ex_store_reg;
    logic [RAW-1:0] ex_dest_reg;
    logic [4:0]     ex_ctrl_reg;

    logic [W-1:0]   src_rf  [2];
    logic [RAW-1:0] src_idx [2];
    logic [W-1:0]   src_fwd [2];

    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b_raw;
    logic [W-1:0]   op_b;
    logic [SW-1:0]  shamt;
    logic           slt_bit;
    logic [W-1:0]   alu_res;
    logic [RAW-1:0] dest_sel;
    logic [4:0]     ctrl_in;

    logic           accept;
    logic           mul_start;
    logic           mul_done;
    logic [W-1:0]   mul_result;
    logic [W-1:0]   mul_store;
    logic [RAW-1:0] mul_dest;
    logic [4:0]     mul_ctrl;
    logic           stall_comb;

    assign src_rf[0]  = bus.rs_data;
    assign src_rf[1]  = bus.rt_data;
    assign src_idx[0] = bus.rs;
    assign src_idx[1] = bus.rt;

    // The youngest producer (EX/MEM) wins over MEM/WB; register 0 is never forwarded.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign src_fwd[gi] =
                (ex_valid_reg && ex_ctrl_reg[0] && (ex_dest_reg != '0) && (ex_dest_reg == src_idx[gi]))
                    ? ex_result_reg :
                (bus.wb_reg_write && (bus.wb_dest != '0) && (bus.wb_dest == src_idx[gi]))
                    ? bus.wb_data : src_rf[gi];
        end
    endgenerate

    assign op_a     = src_fwd[0];
    assign op_b_raw = src_fwd[1];
    assign op_b     = bus.alu_src ? bus.imm : op_b_raw;
    assign shamt    = op_b[SW-1:0];
    assign slt_bit  = $signed(op_a) < $signed(op_b);
    assign dest_sel = bus.reg_dst ? bus.rd : bus.rt;
    assign ctrl_in  = {bus.branch_in, bus.mem_write_in, bus.mem_read_in,
                       bus.mem_to_reg_in, bus.reg_write_in};

    always_comb begin
        alu_res = '0;
        case (bus.alu_op)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_NOR:  alu_res = ~(op_a | op_b);
            OP_SLT:  alu_res = {{(W-1){1'b0}}, slt_bit};
            OP_SLL:  alu_res = op_a << shamt;
            OP_SRL:  alu_res = op_a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
            default: alu_res = '0;
        endcase
    end

`ifdef EX_MUL_EN
    localparam logic [3:0]    OP_MUL   = 4'd10;
    localparam logic [SW-1:0] CNT_LAST = SW'(W - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         state_reg;
    state_t         state_next;
    logic [SW-1:0]  cnt_reg;
    logic [W-1:0]   mcand_reg;
    logic [W-1:0]   mplier_reg;
    logic [W-1:0]   acc_reg;
    logic [W-1:0]   store_lat_reg;
    logic [RAW-1:0] dest_lat_reg;
    logic [4:0]     ctrl_lat_reg;
    logic           mul_step;
    logic           is_mul;

    assign is_mul = bus.in_valid && (bus.alu_op == OP_MUL);
    assign accept = (state_reg == IDLE) && !is_mul;

    // Bit W-1 is folded in combinationally at completion, so a mem_stall wait
    // at the last count never repeats a step.
    assign mul_result = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    assign mul_store  = store_lat_reg;
    assign mul_dest   = dest_lat_reg;
    assign mul_ctrl   = ctrl_lat_reg;

    always_comb begin
        state_next = state_reg;
        mul_start  = 1'b0;
        mul_done   = 1'b0;
        mul_step   = 1'b0;
        stall_comb = 1'b0;
        case (state_reg)
            IDLE: begin
                stall_comb = is_mul;
                if (is_mul && !bus.mem_stall) begin
                    mul_start  = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt_reg == CNT_LAST) begin
                    stall_comb = bus.mem_stall;
                    if (!bus.mem_stall) begin
                        mul_done   = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    stall_comb = 1'b1;
                    mul_step   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (bus.flush) begin
            state_next = IDLE;
            mul_start  = 1'b0;
            mul_done   = 1'b0;
            mul_step   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            acc_reg       <= '0;
            store_lat_reg <= '0;
            dest_lat_reg  <= '0;
            ctrl_lat_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (bus.flush) begin
                cnt_reg <= '0;
            end else if (mul_start) begin
                cnt_reg       <= '0;
                mcand_reg     <= op_a;
                mplier_reg    <= op_b;
                acc_reg       <= '0;
                store_lat_reg <= op_b_raw;
                dest_lat_reg  <= dest_sel;
                ctrl_lat_reg  <= ctrl_in;
            end else if (mul_step) begin
                acc_reg    <= mul_result;
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                cnt_reg    <= cnt_reg + 1'b1;
            end
        end
    end
`else
    assign accept     = 1'b1;
    assign mul_start  = 1'b0;
    assign mul_done   = 1'b0;
    assign mul_result = '0;
    assign mul_store  = '0;
    assign mul_dest   = '0;
    assign mul_ctrl   = '0;
    assign stall_comb = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_reg  <= 1'b0;
            ex_result_reg <= '0;
            ex_zero_reg   <= 1'b0;
            ex_store_reg  <= '0;
            ex_dest_reg   <= '0;
            ex_ctrl_reg   <= '0;
        end else if (bus.flush) begin
            ex_valid_reg <= 1'b0;
            ex_ctrl_reg  <= '0;
        end else if (!bus.mem_stall) begin
            if (mul_start) begin
                ex_valid_reg <= 1'b0;
                ex_ctrl_reg  <= '0;
            end else if (mul_done) begin
                ex_valid_reg  <= 1'b1;
                ex_result_reg <= mul_result;
                ex_zero_reg   <= (mul_result == '0);
                ex_store_reg  <= mul_store;
                ex_dest_reg   <= mul_dest;
                ex_ctrl_reg   <= mul_ctrl;
            end else if (accept) begin
                ex_valid_reg  <= bus.in_valid;
                ex_result_reg <= alu_res;
                ex_zero_reg   <= (alu_res == '0);
                ex_store_reg  <= op_b_raw;
                ex_dest_reg   <= dest_sel;
                ex_ctrl_reg   <= ctrl_in;
            end
        end
    end

    assign bus.stall_out     = stall_comb;
    assign bus.ex_valid      = ex_valid_reg;
    assign bus.ex_result     = ex_result_reg;
    assign bus.ex_zero       = ex_zero_reg;
    assign bus.ex_store_data = ex_store_reg;
    assign bus.ex_dest       = ex_dest_reg;
    assign bus.ex_reg_write  = ex_ctrl_reg[0];
    assign bus.ex_mem_to_reg = ex_ctrl_reg[1];
    assign bus.ex_mem_read   = ex_ctrl_reg[2];
    assign bus.ex_mem_write  = ex_ctrl_reg[3];
    assign bus.ex_branch     = ex_ctrl_reg[4];
endmodule

// File: tb/tb_ex_stage_param.sv
// Scoreboard bench for ex_stage_param (W=32): directed ALU, forwarding, stall and
// flush vectors; multiplier vectors are built when EX_MUL_EN is defined.
module tb_ex_stage_param;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    ex_stage_param_if #(.W(32), .RAW(5)) bus ();
    ex_stage_param #(.W(32), .RAW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] res;
        logic [31:0] st;
        logic [4:0]  dst;
        logic [4:0]  ctl;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic go_idle();
        bus.in_valid      = 1'b0;
        bus.alu_op        = 4'd0;
        bus.rs            = '0;
        bus.rt            = '0;
        bus.rd            = '0;
        bus.rs_data       = '0;
        bus.rt_data       = '0;
        bus.imm           = '0;
        bus.alu_src       = 1'b0;
        bus.reg_dst       = 1'b0;
        {bus.branch_in, bus.mem_write_in, bus.mem_read_in, bus.mem_to_reg_in, bus.reg_write_in} = 5'b0;
        bus.wb_reg_write  = 1'b0;
        bus.wb_dest       = '0;
        bus.wb_data       = '0;
        bus.mem_stall     = 1'b0;
        bus.flush         = 1'b0;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] dst, input logic [31:0] data);
        bus.wb_reg_write = we;
        bus.wb_dest      = dst;
        bus.wb_data      = data;
    endtask

    // Waits for the next falling edge, presents one ID/EX instruction and,
    // when push is set, records the hand-computed EX/MEM contents it must produce.
    task automatic issue(input string tag, input logic [3:0] op,
                         input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                         input logic [31:0] sd, input logic [31:0] td, input logic [31:0] im,
                         input logic asrc, input logic rdst, input logic [4:0] ctl,
                         input logic [31:0] res, input logic [31:0] st, input logic [4:0] dst,
                         input bit push);
        exp_t e;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.rs       = s;
        bus.rt       = t;
        bus.rd       = d;
        bus.rs_data  = sd;
        bus.rt_data  = td;
        bus.imm      = im;
        bus.alu_src  = asrc;
        bus.reg_dst  = rdst;
        {bus.branch_in, bus.mem_write_in, bus.mem_read_in, bus.mem_to_reg_in, bus.reg_write_in} = ctl;
        if (push) begin
            e.res = res;
            e.st  = st;
            e.dst = dst;
            e.ctl = ctl;
            e.tag = tag;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: a new EX/MEM entry appears after any edge that was not reset, flush or stall.
    initial begin
        logic rst_s;
        logic stall_s;
        logic flush_s;
        exp_t e;
        forever begin
            @(posedge clk);
            rst_s   = rst;
            stall_s = bus.mem_stall;
            flush_s = bus.flush;
            #1;
            if (!rst_s && !stall_s && !flush_s && bus.ex_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_output: got result %0h with valid 1, expected no output", bus.ex_result);
                end else begin
                    e = exp_q.pop_front();
                    check({e.tag, ".result"}, 64'(bus.ex_result), 64'(e.res));
                    check({e.tag, ".zero"}, 64'(bus.ex_zero), 64'(e.res == 32'd0));
                    check({e.tag, ".store"}, 64'(bus.ex_store_data), 64'(e.st));
                    check({e.tag, ".dest"}, 64'(bus.ex_dest), 64'(e.dst));
                    check({e.tag, ".ctrl"}, 64'({bus.ex_branch, bus.ex_mem_write, bus.ex_mem_read,
                                                 bus.ex_mem_to_reg, bus.ex_reg_write}), 64'(e.ctl));
                end
            end
        end
    end

    initial begin
        int n;
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b1;
        go_idle();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset.flags", 64'({bus.ex_valid, bus.ex_zero, bus.ex_reg_write, bus.ex_mem_to_reg,
                                  bus.ex_mem_read, bus.ex_mem_write, bus.ex_branch, bus.stall_out}), 64'(0));
        check("reset.result", 64'(bus.ex_result), 64'(0));
        check("reset.store_dest", 64'({bus.ex_store_data, bus.ex_dest}), 64'(0));

        //     tag       op     rs     rt     rd     rs_data        rt_data        imm          src   dst   ctl       result         store          dest
        issue("add_imm", 4'd0,  5'd1,  5'd2,  5'd0,  32'd5,         32'h11,        32'd7,       1'b1, 1'b0, 5'b00001, 32'd12,        32'h11,        5'd2,  1);
        #1 check("add_no_stall", 64'(bus.stall_out), 64'(0));
        issue("sub_zero", 4'd1, 5'd4,  5'd5,  5'd6,  32'd9,         32'd9,         32'd0,       1'b0, 1'b1, 5'b00001, 32'd0,         32'd9,         5'd6,  1);
        issue("wr_r3_a", 4'd0,  5'd1,  5'd3,  5'd0,  32'd1,         32'd0,         32'd3,       1'b1, 1'b0, 5'b00001, 32'd4,         32'd0,         5'd3,  1);
        issue("fwd_ex",  4'd0,  5'd3,  5'd3,  5'd7,  32'd0,         32'd0,         32'd0,       1'b0, 1'b1, 5'b00001, 32'd8,         32'd4,         5'd7,  1);
        issue("wr_r3_b", 4'd0,  5'd1,  5'd3,  5'd0,  32'd1,         32'd0,         32'd3,       1'b1, 1'b0, 5'b00001, 32'd4,         32'd0,         5'd3,  1);
        issue("fwd_ex_over_wb", 4'd0, 5'd3, 5'd3, 5'd7, 32'd0,      32'd0,         32'd0,       1'b0, 1'b1, 5'b00001, 32'd8,         32'd4,         5'd7,  1);
        set_wb(1'b1, 5'd3, 32'd1);
        issue("wb_r0_ignored", 4'd0, 5'd0, 5'd0, 5'd0, 32'd5,       32'd6,         32'd0,       1'b0, 1'b0, 5'b00001, 32'd11,        32'd6,         5'd0,  1);
        set_wb(1'b1, 5'd0, 32'h99);
        issue("ex_r0_ignored", 4'd3, 5'd0, 5'd0, 5'd8, 32'd2,       32'd3,         32'd0,       1'b0, 1'b1, 5'b00001, 32'd3,         32'd3,         5'd8,  1);
        issue("fwd_wb",  4'd4,  5'd9,  5'd9,  5'd10, 32'd0,         32'd0,         32'h0F,      1'b1, 1'b1, 5'b00001, 32'h10F,       32'h100,       5'd10, 1);
        set_wb(1'b1, 5'd9, 32'h100);
        issue("and",     4'd2,  5'd11, 5'd12, 5'd0,  32'hF0F0,      32'hFF00,      32'd0,       1'b0, 1'b0, 5'b00011, 32'hF000,      32'hFF00,      5'd12, 1);
        set_wb(1'b0, 5'd0, 32'd0);
        issue("nor",     4'd5,  5'd13, 5'd14, 5'd0,  32'd0,         32'd0,         32'd0,       1'b0, 1'b0, 5'b00100, 32'hFFFF_FFFF, 32'd0,         5'd14, 1);
        issue("slt_true", 4'd6, 5'd15, 5'd16, 5'd0,  32'hFFFF_FFFF, 32'd1,         32'd0,       1'b0, 1'b0, 5'b01000, 32'd1,         32'd1,         5'd16, 1);
        issue("slt_false", 4'd6, 5'd17, 5'd18, 5'd0, 32'd1,         32'hFFFF_FFFF, 32'd0,       1'b0, 1'b0, 5'b10000, 32'd0,         32'hFFFF_FFFF, 5'd18, 1);
        issue("sll31",   4'd7,  5'd19, 5'd20, 5'd0,  32'd1,         32'd0,         32'd31,      1'b1, 1'b0, 5'b00001, 32'h8000_0000, 32'd0,         5'd20, 1);
        issue("sra4",    4'd9,  5'd21, 5'd22, 5'd0,  32'h8000_0000, 32'd0,         32'h24,      1'b1, 1'b0, 5'b00001, 32'hF800_0000, 32'd0,         5'd22, 1);
        issue("srl4",    4'd8,  5'd23, 5'd24, 5'd0,  32'h8000_0000, 32'd0,         32'd4,       1'b1, 1'b0, 5'b00001, 32'h0800_0000, 32'd0,         5'd24, 1);
        issue("sub_wrap", 4'd1, 5'd25, 5'd26, 5'd0,  32'd0,         32'd1,         32'd0,       1'b0, 1'b0, 5'b00001, 32'hFFFF_FFFF, 32'd1,         5'd26, 1);
        issue("add_wrap", 4'd0, 5'd27, 5'd28, 5'd0,  32'hFFFF_FFFF, 32'd0,         32'd2,       1'b1, 1'b0, 5'b00001, 32'd1,         32'd0,         5'd28, 1);
        issue("op12_zero", 4'd12, 5'd29, 5'd30, 5'd0, 32'd5,        32'd6,         32'd0,       1'b0, 1'b0, 5'b00001, 32'd0,         32'd6,         5'd30, 1);
`ifndef EX_MUL_EN
        issue("op10_zero", 4'd10, 5'd1, 5'd2, 5'd0,  32'd7,         32'd6,         32'd0,       1'b0, 1'b0, 5'b00001, 32'd0,         32'd6,         5'd2,  1);
        #1 check("op10_no_stall", 64'(bus.stall_out), 64'(0));
`endif

        // Downstream stall holds the EX/MEM register while the next instruction waits.
        issue("ms_first", 4'd0, 5'd5,  5'd6,  5'd0,  32'd10,        32'd0,         32'd20,      1'b1, 1'b0, 5'b00001, 32'd30,        32'd0,         5'd6,  1);
        issue("ms_second", 4'd0, 5'd7, 5'd8,  5'd0,  32'd1,         32'd0,         32'd1,       1'b1, 1'b0, 5'b00001, 32'd2,         32'd0,         5'd8,  1);
        bus.mem_stall = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            check("ms_held_result", 64'(bus.ex_result), 64'(30));
            check("ms_held_valid", 64'(bus.ex_valid), 64'(1));
        end
        bus.mem_stall = 1'b0;

        // Flush squashes the slot being written.
        issue("flushed", 4'd0,  5'd9,  5'd10, 5'd0,  32'd1,         32'd0,         32'd1,       1'b1, 1'b0, 5'b00001, 32'd2,         32'd0,         5'd10, 0);
        bus.flush = 1'b1;
        @(negedge clk);
        go_idle();
        #1;
        check("flush_valid", 64'(bus.ex_valid), 64'(0));
        check("flush_reg_write", 64'(bus.ex_reg_write), 64'(0));
        issue("after_flush", 4'd0, 5'd11, 5'd12, 5'd0, 32'd3,       32'd0,         32'd4,       1'b1, 1'b0, 5'b00001, 32'd7,         32'd0,         5'd12, 1);

`ifdef EX_MUL_EN
        // MUL 0xFFFFFFFF x 3: stall_out high for W cycles, product one cycle after it drops.
        issue("mul_ffff_x3", 4'd10, 5'd13, 5'd14, 5'd15, 32'hFFFF_FFFF, 32'd3,     32'd0,       1'b0, 1'b1, 5'b00001, 32'hFFFF_FFFD, 32'd3,         5'd15, 1);
        n = 0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (!bus.stall_out) break;
            n++;
            if (n == 5) check("mul_bubble_valid", 64'(bus.ex_valid), 64'(0));
            @(negedge clk);
        end
        check("mul_stall_cycles", 64'(n), 64'(32));
        @(negedge clk);
        go_idle();

        // mem_stall at the final count delays completion by three cycles.
        issue("mul_memstall", 4'd10, 5'd16, 5'd17, 5'd0, 32'd7,     32'd6,         32'd0,       1'b0, 1'b0, 5'b00001, 32'd42,        32'd6,         5'd17, 1);
        n = 0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (!bus.stall_out) break;
            n++;
            if (n == 32) break;
            @(negedge clk);
        end
        check("mul_ms_pre_cycles", 64'(n), 64'(32));
        repeat (3) begin
            @(negedge clk);
            bus.mem_stall = 1'b1;
            #1;
            check("mul_ms_stall_out", 64'(bus.stall_out), 64'(1));
            check("mul_ms_bubble", 64'(bus.ex_valid), 64'(0));
        end
        @(negedge clk);
        bus.mem_stall = 1'b0;
        #1 check("mul_ms_release", 64'(bus.stall_out), 64'(0));
        @(negedge clk);
        go_idle();

        // Flush mid-multiply abandons it.
        issue("mul_flushed", 4'd10, 5'd18, 5'd19, 5'd0, 32'd5,      32'd5,         32'd0,       1'b0, 1'b0, 5'b00001, 32'd25,        32'd5,         5'd19, 0);
        repeat (5) @(negedge clk);
        go_idle();
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        check("mul_flush_stall", 64'(bus.stall_out), 64'(0));
        check("mul_flush_valid", 64'(bus.ex_valid), 64'(0));
        issue("after_mul_flush", 4'd0, 5'd20, 5'd21, 5'd0, 32'd2,   32'd0,         32'd2,       1'b1, 1'b0, 5'b00001, 32'd4,         32'd0,         5'd21, 1);
`endif

        @(negedge clk);
        go_idle();
        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
